mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It latches the execute-stage bundle, waits for the data-SRAM response to any load or store whose address was accepted in EXE, and aligns and extends load data. It drives the write-back bundle and the forwarding/hazard bundle. It also drops stale SRAM responses belonging to instructions flushed by a write-back exception.

## Interface
Parameters:
- DATA_W, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- es2ms_valid  in  1  EXE holds a valid instruction ready to leave
- ms_allowin  out  1  stage can accept a new instruction this cycle
- es_mem_req  in  1  instruction issued a data-SRAM request whose addr_ok was seen in EXE
- es_ld_op  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}
- es_pc  in  32  instruction PC
- es_rf_we  in  1  instruction writes a GPR
- es_rf_waddr  in  5  destination GPR
- es_result  in  32  ALU result / virtual address (bits [1:0] select byte lane)
- es_ex  in  1  instruction already carries an exception
- data_sram_data_ok  in  1  response strobe, one per accepted request, in order
- data_sram_rdata  in  32  load data, valid with data_ok
- wb_ex  in  1  flush from write-back (exception/ertn/refetch)
- ws_allowin  in  1  WB can accept
- ms2ws_valid  out  1  valid instruction handed to WB
- ms_pc  out  32  PC to WB
- ms_rf_we  out  1  GPR write enable to WB (0 when ms_ex)
- ms_rf_waddr  out  5  GPR address to WB
- ms_rf_wdata  out  32  load result or passed-through es_result
- ms_ex  out  1  exception flag to WB
- ms_rf_zip  out  39  {ms_ld_pending, ms_rf_we & ms_valid, ms_rf_waddr, ms_rf_wdata} for forwarding/stall in ID

## Operation
- ms_valid register: cleared on reset and on wb_ex; else loaded with es2ms_valid when ms_allowin.
- Payload registers load on es2ms_valid & ms_allowin; they are not reset-critical but reset to 0.
- ms_wait = ms_valid & ms_mem_req & ~ms_ex & ~ms_data_got.
- ms_data_got/ms_rdata_buf: set/captured when ms_wait & data_ok & discard_cnt==0 & ~ms2ws fire. Cleared when a new instruction enters.
- ms_ready_go = ~ms_wait | (data_ok & discard_cnt==0).
- ms_allowin = ~ms_valid | ms_ready_go & ws_allowin; ms2ws_valid = ms_valid & ms_ready_go.
- Load data source is data_sram_rdata when consumed same cycle, else ms_rdata_buf. Lane = data >> (8·addr[1:0]).
  - ld_b: sign-extend byte; ld_bu: zero-extend byte.
  - ld_h: sign-extend half; ld_hu: zero-extend half.
  - ld_w: word as is.
  - Non-load: ms_rf_wdata = es_result.
- ms_ld_pending = ms_valid & |ms_ld_op & ~ms_ready_go (ID must stall, not forward).
- Discard counter discard_cnt, 2 bits, saturating at 3:
  - On wb_ex it adds outstanding orphaned responses:
    - +1 if ms_wait & ~data_ok;
    - +1 if es2ms_valid & ms_allowin & es_mem_req & ~es_ex (entering this cycle).
  - Otherwise it decrements on each data_ok while nonzero; that data_ok is ignored.
  - Simultaneous increment and decrement net correctly.

## Timing
- Reset values: ms2ws_valid 0, ms_allowin 1, ms_rf_we 0, ms_ex 0, ms_pc 0, ms_rf_waddr 0, ms_rf_wdata 0, ms_rf_zip 0, discard_cnt 0.
- Non-memory instruction: one cycle in stage, leaves the cycle after entry if ws_allowin.
- Load whose data_ok arrives the cycle after entry: ms2ws_valid that same cycle; data is not registered first.
- data_ok with ws_allowin=0: data is buffered, and the instruction leaves on a later ws_allowin without a second data_ok.
- wb_ex has priority over every capture: ms2ws_valid is 0 in the cycle after wb_ex.
- Reset mid-operation clears all state immediately (async), including discard_cnt.

## Test plan
- ALU op, es_result=0x1234_5678, ws_allowin=1 -> next cycle ms2ws_valid=1, ms_rf_wdata=0x1234_5678.
- ld_b at addr 0x…03, data_ok one cycle after entry with rdata=0x80AA_BBCC -> ms_rf_wdata=0xFFFF_FF80 in the same cycle; ms_ld_pending=1 only the cycle before.
- ld_hu addr 0x…02, data_ok while ws_allowin=0 for 3 cycles, rdata=0xBEEF_0000 -> buffered; wdata=0x0000_BEEF when ws_allowin rises; ms_allowin=0 meanwhile.
- Store waiting for data_ok, wb_ex asserted -> ms_valid=0; discard_cnt=1; next data_ok is ignored; the following load receives its own data_ok correctly.
- wb_ex in the same cycle a load enters from EXE and the resident load is still waiting -> discard_cnt=2; two data_ok are swallowed, no ms2ws_valid.
- es_ex=1 load -> no wait for data_ok, ms_ex=1, ms_rf_we=0, passes in one cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and data bundle between EXE, MEM and WB around the memory stage.
// Also carries the data-SRAM response strobe and the write-back flush.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              es2ms_valid;
    logic              ms_allowin;
    logic              es_mem_req;
    logic [4:0]        es_ld_op;
    logic [DATA_W-1:0] es_pc;
    logic              es_rf_we;
    logic [4:0]        es_rf_waddr;
    logic [DATA_W-1:0] es_result;
    logic              es_ex;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              wb_ex;
    logic              ws_allowin;
    logic              ms2ws_valid;
    logic [DATA_W-1:0] ms_pc;
    logic              ms_rf_we;
    logic [4:0]        ms_rf_waddr;
    logic [DATA_W-1:0] ms_rf_wdata;
    logic              ms_ex;
    logic [DATA_W+6:0] ms_rf_zip;

    modport master (
        output es2ms_valid, es_mem_req, es_ld_op, es_pc, es_rf_we,
        output es_rf_waddr, es_result, es_ex,
        output data_sram_data_ok, data_sram_rdata, wb_ex, ws_allowin,
        input  ms_allowin, ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
        input  ms_rf_wdata, ms_ex, ms_rf_zip
    );

    modport slave (
        input  es2ms_valid, es_mem_req, es_ld_op, es_pc, es_rf_we,
        input  es_rf_waddr, es_result, es_ex,
        input  data_sram_data_ok, data_sram_rdata, wb_ex, ws_allowin,
        output ms_allowin, ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
        output ms_rf_wdata, ms_ex, ms_rf_zip
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for data-SRAM responses, aligns load data,
// and swallows responses that belong to instructions flushed by WB.
module mem_stage #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);
    logic              valid;
    logic              mem_req;
    logic [4:0]        ld_op;
    logic [DATA_W-1:0] pc;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] result;
    logic              ex;
    logic              data_got;
    logic [DATA_W-1:0] rdata_buf;
    logic [1:0]        discard_cnt;

    logic              waiting;
    logic              data_use;
    logic              ready_go;
    logic              allowin;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;
    logic              ld_pending;
    logic              inc_wait;
    logic              inc_in;
    logic              dec;
    logic [2:0]        cnt_sum;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] wdata;

    assign data_use  = bus.data_sram_data_ok & (discard_cnt == 2'd0);
    assign waiting   = valid & mem_req & ~ex & ~data_got;
    assign ready_go  = ~waiting | data_use;
    assign allowin   = ~valid | (ready_go & bus.ws_allowin);
    assign out_valid = valid & ready_go;
    assign in_fire   = bus.es2ms_valid & allowin;
    assign out_fire  = out_valid & bus.ws_allowin;
    assign ld_pending = valid & (|ld_op) & ~ready_go;

    // A waiting instruction whose response is not consumed this cycle
    // leaves an orphan in flight once it is flushed.
    assign inc_wait = bus.wb_ex & waiting & ~data_use;
    assign inc_in   = bus.wb_ex & in_fire & bus.es_mem_req & ~bus.es_ex;
    assign dec      = bus.data_sram_data_ok & (discard_cnt != 2'd0);
    assign cnt_sum  = {1'b0, discard_cnt} + {2'b0, inc_wait}
                    + {2'b0, inc_in} - {2'b0, dec};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid       <= 1'b0;
            mem_req     <= 1'b0;
            ld_op       <= '0;
            pc          <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            result      <= '0;
            ex          <= 1'b0;
            data_got    <= 1'b0;
            rdata_buf   <= '0;
            discard_cnt <= '0;
        end else begin
            if (bus.wb_ex) begin
                valid <= 1'b0;
            end else if (allowin) begin
                valid <= bus.es2ms_valid;
            end
            if (in_fire) begin
                mem_req  <= bus.es_mem_req;
                ld_op    <= bus.es_ld_op;
                pc       <= bus.es_pc;
                rf_we    <= bus.es_rf_we;
                rf_waddr <= bus.es_rf_waddr;
                result   <= bus.es_result;
                ex       <= bus.es_ex;
            end
            if (in_fire || bus.wb_ex) begin
                data_got <= 1'b0;
            end else if (waiting && data_use && !out_fire) begin
                data_got  <= 1'b1;
                rdata_buf <= bus.data_sram_rdata;
            end
            discard_cnt <= (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
        end
    end

    assign src  = data_got ? rdata_buf : bus.data_sram_rdata;
    assign lane = src >> {result[1:0], 3'b000};

    always_comb begin
        wdata = result;
        unique case (1'b1)
            ld_op[4]: wdata = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            ld_op[3]: wdata = {{(DATA_W-8){1'b0}}, lane[7:0]};
            ld_op[2]: wdata = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            ld_op[1]: wdata = {{(DATA_W-16){1'b0}}, lane[15:0]};
            ld_op[0]: wdata = src;
            default:  wdata = result;
        endcase
    end

    assign bus.ms_allowin  = allowin;
    assign bus.ms2ws_valid = out_valid;
    assign bus.ms_pc       = pc;
    assign bus.ms_rf_we    = rf_we & ~ex;
    assign bus.ms_rf_waddr = rf_waddr;
    assign bus.ms_rf_wdata = wdata;
    assign bus.ms_ex       = ex;
    assign bus.ms_rf_zip   = {ld_pending, rf_we & ~ex & valid,
                              rf_waddr, wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: hand-computed vectors per scenario.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(32)) bus ();

    mem_stage #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic idle();
        bus.es2ms_valid       = 1'b0;
        bus.es_mem_req        = 1'b0;
        bus.es_ld_op          = 5'b0;
        bus.es_pc             = 32'h0;
        bus.es_rf_we          = 1'b0;
        bus.es_rf_waddr       = 5'd0;
        bus.es_result         = 32'h0;
        bus.es_ex             = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
        bus.wb_ex             = 1'b0;
        bus.ws_allowin        = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic req, input logic [4:0] op,
                         input logic [31:0] res, input logic [4:0] wa);
        bus.es2ms_valid = 1'b1;
        bus.es_mem_req  = req;
        bus.es_ld_op    = op;
        bus.es_pc       = res + 32'h100;
        bus.es_rf_we    = 1'b1;
        bus.es_rf_waddr = wa;
        bus.es_result   = res;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.ms2ws_valid); end
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%b exp=1", bus.ms_allowin); end
        total++; if (bus.ms_rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.ms_rf_we); end
        total++; if (bus.ms_ex !== 1'b0) begin bad++; $display("FAIL rst_ex got=%b exp=0", bus.ms_ex); end
        total++; if (bus.ms_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.ms_pc); end
        total++; if (bus.ms_rf_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.ms_rf_wdata); end
        total++; if (bus.ms_rf_zip !== 39'h0) begin bad++; $display("FAIL rst_zip got=%h exp=0", bus.ms_rf_zip); end
        total++; if (dut.discard_cnt !== 2'd0) begin bad++; $display("FAIL rst_discard got=%0d exp=0", dut.discard_cnt); end
        step();
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        logic [38:0] z;
        idle();
        enter(1'b0, 5'b0, 32'h1234_5678, 5'd5);
        bus.es_rf_we = 1'b1;
        step();
        idle();
        @(negedge clk);
        z = {1'b0, 1'b1, 5'd5, 32'h1234_5678};
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'h1234_5678) begin bad++; $display("FAIL alu_wdata got=%h exp=12345678", bus.ms_rf_wdata); end
        total++; if (bus.ms_pc !== 32'h1234_5778) begin bad++; $display("FAIL alu_pc got=%h exp=12345778", bus.ms_pc); end
        total++; if (bus.ms_rf_zip !== z) begin bad++; $display("FAIL alu_zip got=%h exp=%h", bus.ms_rf_zip, z); end
        step();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL alu_gone got=%b exp=0", bus.ms2ws_valid); end
        step();
    endtask

    task automatic test_ld_b();
        idle();
        enter(1'b1, 5'b10000, 32'h0000_1003, 5'd7);
        step();
        idle();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL ldb_wait got=%b exp=0", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_zip[38] !== 1'b1) begin bad++; $display("FAIL ldb_pend1 got=%b exp=1", bus.ms_rf_zip[38]); end
        total++; if (bus.ms_allowin !== 1'b0) begin bad++; $display("FAIL ldb_allowin got=%b exp=0", bus.ms_allowin); end
        step();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h80AA_BBCC;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldb_wdata got=%h exp=ffffff80", bus.ms_rf_wdata); end
        total++; if (bus.ms_rf_zip[38] !== 1'b0) begin bad++; $display("FAIL ldb_pend0 got=%b exp=0", bus.ms_rf_zip[38]); end
        step();
        idle();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL ldb_gone got=%b exp=0", bus.ms2ws_valid); end
        step();
    endtask

    task automatic test_ld_hu_buffer();
        idle();
        enter(1'b1, 5'b00010, 32'h0000_2002, 5'd8);
        step();
        idle();
        bus.ws_allowin        = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hBEEF_0000;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL hu_valid0 got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'h0000_BEEF) begin bad++; $display("FAIL hu_wdata0 got=%h exp=0000beef", bus.ms_rf_wdata); end
        for (int i = 0; i < 2; i++) begin
            step();
            bus.data_sram_data_ok = 1'b0;
            bus.data_sram_rdata   = 32'h1234_5678;
            @(negedge clk);
            total++; if (bus.ms_allowin !== 1'b0) begin bad++; $display("FAIL hu_hold_allowin got=%b exp=0", bus.ms_allowin); end
            total++; if (bus.ms_rf_wdata !== 32'h0000_BEEF) begin bad++; $display("FAIL hu_buf got=%h exp=0000beef", bus.ms_rf_wdata); end
        end
        step();
        bus.ws_allowin = 1'b1;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL hu_valid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'h0000_BEEF) begin bad++; $display("FAIL hu_wdata got=%h exp=0000beef", bus.ms_rf_wdata); end
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL hu_allowin got=%b exp=1", bus.ms_allowin); end
        step();
        idle();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL hu_gone got=%b exp=0", bus.ms2ws_valid); end
        step();
    endtask

    task automatic test_flush_store();
        idle();
        enter(1'b1, 5'b0, 32'h0000_3000, 5'd0);
        bus.es_rf_we = 1'b0;
        step();
        idle();
        bus.wb_ex = 1'b1;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL st_wait got=%b exp=0", bus.ms2ws_valid); end
        step();
        idle();
        enter(1'b1, 5'b00001, 32'h0000_4000, 5'd9);
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd1) begin bad++; $display("FAIL st_discard1 got=%0d exp=1", dut.discard_cnt); end
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL st_flushed got=%b exp=0", bus.ms2ws_valid); end
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL st_allowin got=%b exp=1", bus.ms_allowin); end
        step();
        idle();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hDEAD_0000;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL st_stale got=%b exp=0", bus.ms2ws_valid); end
        step();
        bus.data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd0) begin bad++; $display("FAIL st_discard0 got=%0d exp=0", dut.discard_cnt); end
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL st_ld_valid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL st_ld_wdata got=%h exp=cafef00d", bus.ms_rf_wdata); end
        step();
        idle();
    endtask

    task automatic test_flush_double();
        idle();
        enter(1'b1, 5'b00001, 32'h0000_5000, 5'd10);
        step();
        idle();
        bus.wb_ex = 1'b1;
        step();
        idle();
        enter(1'b1, 5'b00001, 32'h0000_5004, 5'd11);
        bus.wb_ex = 1'b1;
        @(negedge clk);
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL dbl_allowin got=%b exp=1", bus.ms_allowin); end
        step();
        idle();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1111_1111;
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd2) begin bad++; $display("FAIL dbl_discard2 got=%0d exp=2", dut.discard_cnt); end
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL dbl_valid0 got=%b exp=0", bus.ms2ws_valid); end
        step();
        bus.data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd1) begin bad++; $display("FAIL dbl_discard1 got=%0d exp=1", dut.discard_cnt); end
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL dbl_valid1 got=%b exp=0", bus.ms2ws_valid); end
        step();
        idle();
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd0) begin bad++; $display("FAIL dbl_discard0 got=%0d exp=0", dut.discard_cnt); end
        step();
    endtask

    task automatic test_es_ex();
        idle();
        enter(1'b1, 5'b00001, 32'h0000_6000, 5'd3);
        bus.es_ex = 1'b1;
        step();
        idle();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL ex_valid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_ex !== 1'b1) begin bad++; $display("FAIL ex_flag got=%b exp=1", bus.ms_ex); end
        total++; if (bus.ms_rf_we !== 1'b0) begin bad++; $display("FAIL ex_we got=%b exp=0", bus.ms_rf_we); end
        total++; if (bus.ms_rf_zip[38:37] !== 2'b00) begin bad++; $display("FAIL ex_zip got=%b exp=00", bus.ms_rf_zip[38:37]); end
        step();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL ex_gone got=%b exp=0", bus.ms2ws_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        idle();
        enter(1'b0, 5'b0, 32'hAAAA_0001, 5'd1);
        step();
        enter(1'b0, 5'b0, 32'hBBBB_0002, 5'd2);
        @(negedge clk);
        total++; if (bus.ms_rf_wdata !== 32'hAAAA_0001) begin bad++; $display("FAIL b2b_a got=%h exp=aaaa0001", bus.ms_rf_wdata); end
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL b2b_allowin got=%b exp=1", bus.ms_allowin); end
        step();
        idle();
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b1) begin bad++; $display("FAIL b2b_bvalid got=%b exp=1", bus.ms2ws_valid); end
        total++; if (bus.ms_rf_wdata !== 32'hBBBB_0002) begin bad++; $display("FAIL b2b_b got=%h exp=bbbb0002", bus.ms_rf_wdata); end
        total++; if (bus.ms_rf_waddr !== 5'd2) begin bad++; $display("FAIL b2b_waddr got=%0d exp=2", bus.ms_rf_waddr); end
        step();
    endtask

    task automatic test_async_reset();
        idle();
        enter(1'b1, 5'b0, 32'h0000_7000, 5'd0);
        step();
        idle();
        bus.wb_ex = 1'b1;
        step();
        idle();
        enter(1'b1, 5'b00001, 32'h0000_7004, 5'd12);
        step();
        idle();
        @(negedge clk);
        total++; if (dut.discard_cnt !== 2'd1) begin bad++; $display("FAIL ar_pre got=%0d exp=1", dut.discard_cnt); end
        #1 resetn = 1'b0;
        #1;
        total++; if (dut.discard_cnt !== 2'd0) begin bad++; $display("FAIL ar_discard got=%0d exp=0", dut.discard_cnt); end
        total++; if (bus.ms_allowin !== 1'b1) begin bad++; $display("FAIL ar_allowin got=%b exp=1", bus.ms_allowin); end
        total++; if (bus.ms_rf_zip !== 39'h0) begin bad++; $display("FAIL ar_zip got=%h exp=0", bus.ms_rf_zip); end
        step();
        resetn = 1'b1;
        @(negedge clk);
        total++; if (bus.ms2ws_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.ms2ws_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_b();
        test_ld_hu_buffer();
        test_flush_store();
        test_flush_double();
        test_es_ex();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
